// File: rtl/lsu_mem_if.sv
// Load/store unit sitting between the multi-cycle core and the data memory.
// Define LSU_MISALIGN_TRAP_EN to flag and suppress misaligned halfword/word accesses.
module lsu_mem_if #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_start,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_busy,
    output logic              lsu_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_sdata,
    output logic              mem_lenable,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_ldata
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    state_t     state;
    logic       we_q;
    logic [2:0] f3_q;
    logic       skip_q;
    logic       unsup_q;
    logic       misal_q;

    logic       req_ok;
    logic       req_mis;
    logic       req_skip;

    function automatic logic f3_supported(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else    ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (f3 == 3'b100) || (f3 == 3'b101);
        return ok;
    endfunction

    // Size lives in funct3[1:0] for both signed and unsigned loads.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'(4'b0001 << a);
            2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{w[7:0]}};
            2'b01:   d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        req_ok   = f3_supported(lsu_we, lsu_funct3);
        req_mis  = TRAP_EN && req_ok && is_misaligned(lsu_funct3, lsu_addr[1:0]);
        req_skip = !req_ok || req_mis;
    end

    // Memory strobes are registered at request acceptance so they are live during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            skip_q       <= 1'b0;
            unsup_q      <= 1'b0;
            misal_q      <= 1'b0;
            lsu_rdata    <= 32'd0;
            lsu_done     <= 1'b0;
            lsu_busy     <= 1'b0;
            lsu_misalign <= 1'b0;
            mem_addr     <= '0;
            mem_sdata    <= 32'd0;
            mem_lenable  <= 1'b0;
            mem_mask     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_start) begin
                        state       <= ACCESS;
                        lsu_busy    <= 1'b1;
                        we_q        <= lsu_we;
                        f3_q        <= lsu_funct3;
                        unsup_q     <= !req_ok;
                        misal_q     <= req_mis;
                        skip_q      <= req_skip;
                        mem_addr    <= lsu_addr;
                        mem_sdata   <= store_data(lsu_funct3, lsu_wdata);
                        mem_mask    <= (!req_skip && lsu_we) ? store_mask(lsu_funct3, lsu_addr[1:0])
                                                             : 4'd0;
                        mem_lenable <= !req_skip && !lsu_we;
                    end
                end
                ACCESS: begin
                    mem_mask    <= 4'd0;
                    mem_lenable <= 1'b0;
                    if (skip_q) begin
                        state        <= DONE;
                        lsu_done     <= 1'b1;
                        lsu_misalign <= misal_q;
                        if (unsup_q && !we_q) lsu_rdata <= 32'd0;
                    end else if (we_q) begin
                        state    <= DONE;
                        lsu_done <= 1'b1;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    lsu_rdata <= load_extend(f3_q, mem_addr[1:0], mem_ldata);
                    state     <= DONE;
                    lsu_done  <= 1'b1;
                end
                DONE: begin
                    state        <= IDLE;
                    lsu_done     <= 1'b0;
                    lsu_misalign <= 1'b0;
                    lsu_busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed self-checking bench for lsu_mem_if with a byte-masked, one-cycle-read memory model.
module tb_lsu_mem_if;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_start = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'd0;
    logic [31:0] lsu_addr = 32'd0;
    logic [31:0] lsu_wdata = 32'd0;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_busy;
    logic        lsu_misalign;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        mem_lenable;
    logic [3:0]  mem_mask;
    logic [31:0] mem_ldata = 32'd0;

    int errors = 0;
    int checks = 0;

    int          dc, dn;
    logic [3:0]  m1;
    logic [31:0] s1;
    logic        l1, b1, la, ma, mi;

    lsu_mem_if #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .lsu_start(lsu_start), .lsu_we(lsu_we),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_busy(lsu_busy),
        .lsu_misalign(lsu_misalign), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .mem_lenable(mem_lenable), .mem_mask(mem_mask), .mem_ldata(mem_ldata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_lenable) mem_ldata <= mem[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (mem_mask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_sdata[8*b +: 8];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One request; observes 8 cycles after the start cycle (cycle 1 = ACCESS).
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int restart_cyc,
                          output int done_cyc, output int done_cnt, output logic [3:0] mask1,
                          output logic [31:0] sdata1, output logic len1, output logic busy1,
                          output logic len_any, output logic mask_any, output logic mis);
        @(negedge clk);
        lsu_start = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
        @(negedge clk);
        lsu_start = 1'b0;
        done_cyc = 0; done_cnt = 0; len_any = 1'b0; mask_any = 1'b0; mis = 1'b0;
        mask1 = mem_mask; sdata1 = mem_sdata; len1 = mem_lenable; busy1 = lsu_busy;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            if (c == restart_cyc) begin
                lsu_start = 1'b1; lsu_addr = 32'h200; lsu_funct3 = 3'b000;
            end else begin
                lsu_start = 1'b0;
            end
            len_any  = len_any | mem_lenable;
            mask_any = mask_any | (|mem_mask);
            if (lsu_done) begin
                done_cnt++;
                if (done_cyc == 0) begin done_cyc = c; mis = lsu_misalign; end
            end
        end
        lsu_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({lsu_rdata, lsu_done, lsu_busy, lsu_misalign} !== 35'd0) begin errors++;
            $display("FAIL reset_core_outs got=%h exp=0", {lsu_rdata, lsu_done, lsu_busy, lsu_misalign}); end
        checks++; if ({mem_addr, mem_sdata, mem_lenable, mem_mask} !== 69'd0) begin errors++;
            $display("FAIL reset_mem_outs got=%h exp=0", {mem_addr, mem_sdata, mem_lenable, mem_mask}); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (m1 !== 4'b1111) begin errors++; $display("FAIL sw_mask got=%b exp=1111", m1); end
        checks++; if (s1 !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_sdata got=%h exp=deadbeef", s1); end
        checks++; if (b1 !== 1'b1 || l1 !== 1'b0) begin errors++; $display("FAIL sw_busy_len got=%b%b exp=10", b1, l1); end
        checks++; if (dc !== 2 || dn !== 1) begin errors++; $display("FAIL sw_done got cyc=%0d cnt=%0d exp cyc=2 cnt=1", dc, dn); end
        checks++; if (lsu_rdata !== 32'd0) begin errors++; $display("FAIL sw_rdata_hold got=%h exp=0", lsu_rdata); end
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (l1 !== 1'b1 || m1 !== 4'b0000) begin errors++; $display("FAIL lw_strobes got len=%b mask=%b exp len=1 mask=0000", l1, m1); end
        checks++; if (lsu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", lsu_rdata); end
        checks++; if (dc !== 3 || dn !== 1) begin errors++; $display("FAIL lw_done got cyc=%0d cnt=%0d exp cyc=3 cnt=1", dc, dn); end
    endtask

    task automatic test_byte();
        run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (m1 !== 4'b1000) begin errors++; $display("FAIL sb_mask got=%b exp=1000", m1); end
        checks++; if (s1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_sdata got=%h exp=a5a5a5a5", s1); end
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_103 got=%h exp=ffffffa5", lsu_rdata); end
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'h000000A5) begin errors++; $display("FAIL lbu_103 got=%h exp=000000a5", lsu_rdata); end
        run_op(1'b0, 3'b000, 32'h100, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_100 got=%h exp=ffffffef", lsu_rdata); end
        run_op(1'b0, 3'b100, 32'h101, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'h000000BE) begin errors++; $display("FAIL lbu_101 got=%h exp=000000be", lsu_rdata); end
    endtask

    task automatic test_half();
        run_op(1'b1, 3'b001, 32'h202, 32'h00008001, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (m1 !== 4'b1100) begin errors++; $display("FAIL sh_mask got=%b exp=1100", m1); end
        checks++; if (s1 !== 32'h80018001) begin errors++; $display("FAIL sh_sdata got=%h exp=80018001", s1); end
        run_op(1'b0, 3'b001, 32'h202, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_202 got=%h exp=ffff8001", lsu_rdata); end
        run_op(1'b0, 3'b101, 32'h202, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_202 got=%h exp=00008001", lsu_rdata); end
        run_op(1'b0, 3'b101, 32'h100, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_100 got=%h exp=0000beef", lsu_rdata); end
    endtask

    task automatic test_busy_ignore();
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 2, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (dn !== 1 || dc !== 3) begin errors++; $display("FAIL busy_ignore got cnt=%0d cyc=%0d exp cnt=1 cyc=3", dn, dc); end
        checks++; if (lsu_rdata !== 32'hA5ADBEEF) begin errors++; $display("FAIL busy_rdata got=%h exp=a5adbeef", lsu_rdata); end
        checks++; if (lsu_busy !== 1'b0) begin errors++; $display("FAIL busy_idle got=%b exp=0", lsu_busy); end
    endtask

    task automatic test_funct3();
        run_op(1'b1, 3'b011, 32'h100, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (ma !== 1'b0 || la !== 1'b0) begin errors++; $display("FAIL bad_store_access got mask=%b len=%b exp 0 0", ma, la); end
        checks++; if (dc !== 2 || dn !== 1) begin errors++; $display("FAIL bad_store_done got cyc=%0d cnt=%0d exp cyc=2 cnt=1", dc, dn); end
        checks++; if (lsu_rdata !== 32'hA5ADBEEF) begin errors++; $display("FAIL bad_store_rdata got=%h exp=a5adbeef", lsu_rdata); end
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (la !== 1'b0) begin errors++; $display("FAIL bad_load_len got=%b exp=0", la); end
        checks++; if (lsu_rdata !== 32'd0) begin errors++; $display("FAIL bad_load_rdata got=%h exp=0", lsu_rdata); end
        checks++; if (dc !== 2 || dn !== 1) begin errors++; $display("FAIL bad_load_done got cyc=%0d cnt=%0d exp cyc=2 cnt=1", dc, dn); end
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'hA5ADBEEF) begin errors++; $display("FAIL mem_untouched got=%h exp=a5adbeef", lsu_rdata); end
    endtask

    task automatic test_mid_reset();
        int nd;
        @(negedge clk);
        lsu_start = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h100;
        @(negedge clk);
        lsu_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({lsu_rdata, lsu_done, lsu_busy, lsu_misalign} !== 35'd0) begin errors++;
            $display("FAIL midrst_core_outs got=%h exp=0", {lsu_rdata, lsu_done, lsu_busy, lsu_misalign}); end
        checks++; if ({mem_addr, mem_sdata, mem_lenable, mem_mask} !== 69'd0) begin errors++;
            $display("FAIL midrst_mem_outs got=%h exp=0", {mem_addr, mem_sdata, mem_lenable, mem_mask}); end
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (lsu_done) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", nd); end
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
        checks++; if (lsu_rdata !== 32'hA5ADBEEF || dc !== 3) begin errors++;
            $display("FAIL midrst_next_lw got=%h cyc=%0d exp=a5adbeef cyc=3", lsu_rdata, dc); end
    endtask

    task automatic test_misalign();
        run_op(1'b0, 3'b001, 32'h203, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (mi !== 1'b1 || la !== 1'b0 || dc !== 2) begin errors++;
            $display("FAIL mis_lh got mis=%b len=%b cyc=%0d exp 1 0 2", mi, la, dc); end
        checks++; if (lsu_rdata !== 32'hA5ADBEEF) begin errors++; $display("FAIL mis_lh_rdata got=%h exp=a5adbeef", lsu_rdata); end
`else
        checks++; if (mi !== 1'b0 || dc !== 3) begin errors++; $display("FAIL mis_lh got mis=%b cyc=%0d exp 0 3", mi, dc); end
        checks++; if (lsu_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL mis_lh_rdata got=%h exp=ffff8001", lsu_rdata); end
`endif
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 0, dc, dn, m1, s1, l1, b1, la, ma, mi);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (mi !== 1'b1 || la !== 1'b0 || dc !== 2) begin errors++;
            $display("FAIL mis_lw got mis=%b len=%b cyc=%0d exp 1 0 2", mi, la, dc); end
`else
        checks++; if (mi !== 1'b0 || la !== 1'b1 || dc !== 3) begin errors++;
            $display("FAIL mis_lw got mis=%b len=%b cyc=%0d exp 0 1 3", mi, la, dc); end
`endif
        checks++; if (lsu_rdata !== 32'hA5ADBEEF) begin errors++; $display("FAIL mis_lw_rdata got=%h exp=a5adbeef", lsu_rdata); end
        checks++; if (lsu_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", lsu_misalign); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_busy_ignore();
        test_funct3();
        test_mid_reset();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit sitting directly upstream of the data memory.
- Accepts one load/store request per handshake from the multi-cycle RV32I core (5 cycles per instruction) and drives the memory bus: byte-lane mask, lane-aligned store data and load enable.
- After the memory's one-cycle registered read, extracts and sign/zero-extends LB/LH/LW/LBU/LHU results and returns them to the core with a done pulse.

Parameters:
- ADDR_W, 32, width of the request and memory address.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lsu_start  in  1  one-cycle request pulse; sampled only in IDLE.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- lsu_addr  in  32  byte address (rs1 + imm).
- lsu_wdata  in  32  store data (rs2).
- lsu_rdata  out  32  extended load result; registered.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_busy  out  1  high whenever state is not IDLE.
- lsu_misalign  out  1  misaligned-access flag; valid with lsu_done.
- mem_addr  out  32  byte address to memory; the memory uses bits [31:2].
- mem_sdata  out  32  store data replicated to the selected byte lanes.
- mem_lenable  out  1  load enable to memory.
- mem_mask  out  4  byte write enables.
- mem_ldata  in  32  memory read data; valid the cycle after mem_lenable is sampled.

Behaviour:
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - On lsu_start=1, latch we/funct3/addr/wdata and go to ACCESS.
  - lsu_start in any other state is ignored (no queueing).
- ACCESS, exactly one cycle:
  - Load: mem_lenable=1, mem_mask=0, then go to CAPTURE.
  - Store: mem_mask per the rules below, mem_lenable=0, then go to DONE.
  - Outside ACCESS: mem_lenable=0 and mem_mask=0. mem_addr and mem_sdata hold the latched values.
- CAPTURE:
  - Take byte lane addr[1:0] or half lane addr[1] from mem_ldata.
  - Extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Register the result into lsu_rdata, then go to DONE.
- DONE: lsu_done=1 for exactly one cycle, then return to IDLE. lsu_rdata holds its value until the next load completes; stores do not change it.
- Latency, counting the cycle lsu_start is sampled as 0:
  - Load: ACCESS in cycle 1, CAPTURE in cycle 2, lsu_done in cycle 3.
  - Store: ACCESS in cycle 1, lsu_done in cycle 2.
  - lsu_busy is high in cycles 1..done.
- Store lanes:
  - SB: mask = 0001 << addr[1:0], sdata = {4{wdata[7:0]}}.
  - SH: mask = addr[1] ? 1100 : 0011, sdata = {2{wdata[15:0]}}.
  - SW: mask = 1111, sdata = wdata.
- Unsupported funct3 (load 011/110/111, store 011..111):
  - No memory access: ACCESS drives mask=0 and lenable=0, and the FSM goes directly to DONE.
  - For loads lsu_rdata is set to 0.
  - lsu_done still pulses, so the core never hangs.
- Reset (including mid-operation):
  - State returns to IDLE. lsu_rdata, lsu_done, lsu_busy, lsu_misalign, mem_addr, mem_sdata, mem_lenable and mem_mask all go to 0.
  - A store interrupted before ACCESS writes nothing.
  - An in-flight load produces no done pulse.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠00, is flagged as misaligned.
  - The memory access is suppressed (mask=0, lenable=0) and the FSM goes ACCESS→DONE.
  - lsu_misalign=1 together with lsu_done. lsu_rdata is unchanged.
- Undefined:
  - lsu_misalign is tied to 0.
  - Ignored address bits are treated as zero: halfword ignores addr[0], word ignores addr[1:0]. The access completes normally.

Test Plan:
- Store: SW addr 0x100, wdata 0xDEADBEEF → mask=1111 in cycle 1, done in cycle 2. Then LW 0x100 → lsu_rdata=0xDEADBEEF, done in cycle 3.
- Byte lanes: SB addr 0x103, wdata 0x000000A5 → mask=1000, sdata=0xA5A5A5A5. Then LB 0x103 → 0xFFFFFFA5, and LBU 0x103 → 0x000000A5.
- Halfwords: SH addr 0x202, wdata 0x00008001 → mask=1100. Then LH 0x202 → 0xFFFF8001, and LHU 0x202 → 0x00008001.
- Busy and funct3: lsu_start pulsed again during a load's CAPTURE → ignored, exactly one done. A load with funct3=011 → no lenable, lsu_rdata=0, done in cycle 2.
- Reset: rst asserted in CAPTURE → all outputs 0 the next cycle, no done. The next LW completes normally.
- Misaligned LW 0x101:
  - With LSU_MISALIGN_TRAP_EN: lsu_misalign=1 with done, lenable never high.
  - Without it: reads word 0x100.
